par2ser8: RTL and testbench

Eight-bit parallel-to-serial converter built around the team's 8:1 select structure (output bit = held_word[sel]). Upstream it accepts a byte over a valid/ready handshake and holds it. It then steps its own 3-bit select counter to stream the byte one bit per transfer over a downstream valid/ready handshake. It sits between byte-wide producers and single-wire consumers; it holds one word, and a new byte is accepted in the final bit's transfer cycle so streams are gapless.

---
 rtl/par2ser8_if.sv | 22 ++
 rtl/par2ser8.sv | 81 ++++++++
 tb/tb_par2ser8.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/par2ser8_if.sv
// Byte-in / bit-out handshake bundle for par2ser8: master is the converter, slave the surrounding producer/consumer.
interface par2ser8_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       y;
  logic       y_valid;
  logic       y_ready;
  logic       y_first;
  logic       y_last;
  logic       busy;

  modport master (
    input  din, din_valid, y_ready,
    output din_ready, y, y_valid, y_first, y_last, busy
  );

  modport slave (
    output din, din_valid, y_ready,
    input  din_ready, y, y_valid, y_first, y_last, busy
  );
endinterface

// File: rtl/par2ser8.sv
// 8-bit parallel-to-serial converter (y = word[sel]); PAR2SER_PARITY_EN appends an even-parity bit.
// Latency: first bit on y the cycle after the accept edge; frames of 8 bits (9 with parity).
// Backpressure: y_ready=0 freezes sel/word/outputs; din_ready only in IDLE or on the accepted last beat.
module par2ser8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  par2ser8_if.master bus
);

  localparam logic [2:0] START_SEL = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST_SEL  = MSB_FIRST ? 3'd0 : 3'd7;

`ifdef PAR2SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t     state;
  logic [7:0] word;
  logic [2:0] sel;

  logic data_last;
  logic last_beat;
  logic up_xfer;
  logic dn_xfer;
  logic y_bit;

  assign data_last = (state == SHIFT) && (sel == LAST_SEL);

`ifdef PAR2SER_PARITY_EN
  assign last_beat = (state == PARITY);
`else
  assign last_beat = data_last;
`endif

  // Accepting on the last beat lets a new frame follow with no idle cycle.
  assign bus.din_ready = !rst && ((state == IDLE) || (last_beat && bus.y_ready));
  assign bus.y_valid   = (state != IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.y_first   = (state == SHIFT) && (sel == START_SEL);
  assign bus.y_last    = last_beat;
  assign bus.y         = y_bit;

  assign up_xfer = bus.din_valid && bus.din_ready;
  assign dn_xfer = bus.y_valid && bus.y_ready;

  always_comb begin
    y_bit = 1'b0;
    if (state == SHIFT)
      y_bit = word[sel];
`ifdef PAR2SER_PARITY_EN
    else if (state == PARITY)
      y_bit = ^word;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      sel   <= '0;
    end else if (up_xfer) begin
      word  <= bus.din;
      sel   <= START_SEL;
      state <= SHIFT;
    end else if (dn_xfer) begin
      if ((state == SHIFT) && !data_last)
        sel <= MSB_FIRST ? (sel - 3'd1) : (sel + 3'd1);
`ifdef PAR2SER_PARITY_EN
      else if (state == SHIFT)
        state <= PARITY;
`endif
      else
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_par2ser8.sv
// Bench for par2ser8: LSB-first and MSB-first instances driven in lockstep, table vectors plus corner sequences.
module tb_par2ser8;

`ifdef PAR2SER_PARITY_EN
  localparam int FL  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       y_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  par2ser8_if bus0();
  par2ser8_if bus1();

  assign bus0.din       = din;
  assign bus0.din_valid = din_valid;
  assign bus0.y_ready   = y_ready;
  assign bus1.din       = din;
  assign bus1.din_valid = din_valid;
  assign bus1.y_ready   = y_ready;

  par2ser8 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  par2ser8 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  typedef struct {
    logic [7:0] din;
    logic [7:0] seq_lsb;
    logic [7:0] seq_msb;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {y, y_first, y_last} expected for beat i of a frame carrying d.
  function automatic logic [2:0] exp_bit(input logic [7:0] d, input bit msb, input int i);
    int idx;
    if (i == 8) return {^d, 1'b0, 1'b1};
    idx = msb ? 7 - i : i;
    return {d[idx], (i == 0), (i == 7) && !PAR};
  endfunction

  // Scoreboard: frames queued when an accept is seen, bits popped on each downstream transfer.
  always @(negedge clk) begin
    logic [2:0] e;
    if (!rst) begin
      if (bus0.y_valid && y_ready) begin
        if (q0.size() == 0) chk("sb0_underflow", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("sb0_bit", 32'({bus0.y, bus0.y_first, bus0.y_last}), 32'(e));
        end
      end
      if (bus1.y_valid && y_ready) begin
        if (q1.size() == 0) chk("sb1_underflow", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("sb1_bit", 32'({bus1.y, bus1.y_first, bus1.y_last}), 32'(e));
        end
      end
      if (din_valid && bus0.din_ready)
        for (int i = 0; i < FL; i++) q0.push_back(exp_bit(din, 1'b0, i));
      if (din_valid && bus1.din_ready)
        for (int i = 0; i < FL; i++) q1.push_back(exp_bit(din, 1'b1, i));
    end
  end

  task automatic chk_idle(input string name);
    chk({name, "_idle0"}, 32'({bus0.busy, bus0.y_valid, bus0.din_ready, bus0.y}), 32'b0010);
    chk({name, "_idle1"}, 32'({bus1.busy, bus1.y_valid, bus1.din_ready, bus1.y}), 32'b0010);
  endtask

  task automatic send_single(input logic [7:0] d, output logic [31:0] s0, output logic [31:0] s1);
    s0 = '0;
    s1 = '0;
    @(posedge clk); #1;
    din = d;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      s0 = {s0[30:0], bus0.y};
      s1 = {s1[30:0], bus1.y};
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] s0, s1, v, r, e0, e1;

    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h01, 8'h80, 8'h01, 1'b1};
    vecs[2] = '{8'h07, 8'hE0, 8'h07, 1'b1};
    vecs[3] = '{8'h03, 8'hC0, 8'h03, 1'b0};
    vecs[4] = '{8'h0F, 8'hF0, 8'h0F, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'hC3, 8'hC3, 8'hC3, 1'b0};

    // Reset state
    #3;
    chk("rst_out0", 32'({bus0.din_ready, bus0.y, bus0.y_valid, bus0.y_first, bus0.y_last, bus0.busy}), 32'd0);
    chk("rst_out1", 32'({bus1.din_ready, bus1.y, bus1.y_valid, bus1.y_first, bus1.y_last, bus1.busy}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_idle("post_rst");

    // Table-driven single frames
    foreach (vecs[n]) begin
      send_single(vecs[n].din, s0, s1);
      e0 = PAR ? {23'b0, vecs[n].seq_lsb, vecs[n].par} : {24'b0, vecs[n].seq_lsb};
      e1 = PAR ? {23'b0, vecs[n].seq_msb, vecs[n].par} : {24'b0, vecs[n].seq_msb};
      chk($sformatf("seq_lsb_%02h", vecs[n].din), s0, e0);
      chk($sformatf("seq_msb_%02h", vecs[n].din), s1, e1);
      chk_idle("single");
    end

    // Back-to-back 0x0F then 0xF0
    s0 = '0; s1 = '0; v = '0; r = '0;
    @(posedge clk); #1;
    din = 8'h0F;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'hF0;
    for (int k = 0; k < 2 * FL; k++) begin
      @(negedge clk);
      s0 = {s0[30:0], bus0.y};
      s1 = {s1[30:0], bus1.y};
      v  = {v[30:0], bus0.y_valid};
      r  = {r[30:0], bus0.din_ready};
      @(posedge clk); #1;
      if (r[0]) din_valid = 1'b0;
    end
    chk("b2b_seq_lsb", s0, PAR ? 32'b111100000000011110 : 32'h0000F00F);
    chk("b2b_seq_msb", s1, PAR ? 32'b000011110111100000 : 32'h00000FF0);
    chk("b2b_valid", v, 32'((1 << (2 * FL)) - 1));
    chk("b2b_ready", r, 32'((1 << FL) | 1));
    @(negedge clk);
    chk_idle("b2b");

    // Stall on the first bit, then on the last beat with a byte waiting
    @(posedge clk); #1;
    din = 8'h01;
    din_valid = 1'b1;
    y_ready = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_first0", 32'({bus0.y, bus0.y_valid, bus0.y_first, bus0.din_ready}), 32'b1110);
      chk("stall_first1", 32'({bus1.y, bus1.y_valid, bus1.y_first, bus1.din_ready}), 32'b0110);
    end
    @(posedge clk); #1;
    y_ready = 1'b1;
    repeat (FL - 1) @(posedge clk);
    #1;
    y_ready = 1'b0;
    din = 8'h55;
    din_valid = 1'b1;
    @(negedge clk);
    chk("stall_last0", 32'({bus0.y_valid, bus0.y_last, bus0.din_ready}), 32'b110);
    chk("stall_last1", 32'({bus1.y_valid, bus1.y_last, bus1.din_ready}), 32'b110);
    @(posedge clk); #1;
    y_ready = 1'b1;
    @(negedge clk);
    chk("last_ready0", 32'(bus0.din_ready), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (FL) @(posedge clk);
    @(negedge clk);
    chk_idle("stall");

    // Reset mid-frame after four bits of 0xFF
    @(posedge clk); #1;
    din = 8'hFF;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst0", 32'({bus0.din_ready, bus0.y, bus0.y_valid, bus0.y_first, bus0.y_last, bus0.busy}), 32'd0);
    chk("midrst1", 32'({bus1.din_ready, bus1.y, bus1.y_valid, bus1.y_first, bus1.y_last, bus1.busy}), 32'd0);
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_idle("midrst_release");
    send_single(8'h80, s0, s1);
    chk("after_rst_lsb", s0, PAR ? 32'b000000011 : 32'b00000001);
    chk("after_rst_msb", s1, PAR ? 32'b100000001 : 32'b10000000);
    chk_idle("after_rst");

    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
